// File: rtl/tt_multi_design_adapter_pkg.sv
// Shared types and helpers for the multi-design adapter: FSM state enum,
// pad bus width, and the byte-slice selector used by the output mux.
package tt_adapter_pkg;

  localparam int TT_BUS_W    = 8;
  localparam int MAX_DESIGNS = 16;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    QUIESCE = 2'd1,
    RESET   = 2'd2
  } adapter_state_e;

  // Buses are zero-extended to the 16-design maximum before slicing.
  function automatic logic [TT_BUS_W-1:0] slice8(
    input logic [TT_BUS_W*MAX_DESIGNS-1:0] bus,
    input logic [3:0]                      idx
  );
    return bus[idx*TT_BUS_W +: TT_BUS_W];
  endfunction

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/tt_multi_design_adapter_if.sv
// Pad-side and design-side signal bundle of the adapter. The slave modport is
// the adapter's view; designs read ui_in/uio_in straight from this bundle.
interface tt_multi_design_adapter_if #(
  parameter int N_DESIGNS = 4,
  parameter int SEL_W     = 2
);
  import tt_adapter_pkg::*;

  // Handshake: sel_load is a single-cycle strobe, sampled with sel_in on the
  // rising clock edge; there is no ready, busy only reports an ongoing switch.
  logic [SEL_W-1:0]       sel_in;
  logic                   sel_load;
  logic [7:0]             ui_in;
  logic [7:0]             uio_in;
  logic [7:0]             uo_out;
  logic [7:0]             uio_out;
  logic [7:0]             uio_oe;
  logic [N_DESIGNS-1:0]   d_ena;
  logic [N_DESIGNS-1:0]   d_rst_n;
  logic [8*N_DESIGNS-1:0] d_uo_out;
  logic [8*N_DESIGNS-1:0] d_uio_out;
  logic [8*N_DESIGNS-1:0] d_uio_oe;
  logic [SEL_W-1:0]       active_sel;
  logic                   busy;
  logic                   sel_err;
  adapter_state_e         dbg_state;

  modport slave (
    input  sel_in, sel_load, d_uo_out, d_uio_out, d_uio_oe,
    output uo_out, uio_out, uio_oe, d_ena, d_rst_n,
    output active_sel, busy, sel_err, dbg_state
  );

  modport master (
    output sel_in, sel_load, ui_in, uio_in, d_uo_out, d_uio_out, d_uio_oe,
    input  uo_out, uio_out, uio_oe, d_ena, d_rst_n,
    input  active_sel, busy, sel_err, dbg_state
  );

endinterface

// File: rtl/tt_multi_design_adapter_rst_sequencer.sv
// Switch sequencer: RUN -> QUIESCE -> RESET -> RUN, with pending selection,
// a queued second switch when a load lands during RESET, and sel_err pulse.
module tt_rst_sequencer
  import tt_adapter_pkg::*;
#(
  parameter int N_DESIGNS   = 4,
  parameter int SEL_W       = 2,
  parameter int DEFAULT_SEL = 0,
  parameter int RST_HOLD    = 16,
  parameter int QUIESCE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] i_sel_in,
  input  logic             i_sel_load,
  output adapter_state_e   o_state,
  output logic [SEL_W-1:0] o_active_sel,
  output logic             o_sel_err
);

  localparam int               CNT_W  = cnt_width(RST_HOLD, QUIESCE_CYC);
  localparam logic [CNT_W-1:0] Q_INIT = CNT_W'(QUIESCE_CYC - 1);
  localparam logic [CNT_W-1:0] R_INIT = CNT_W'(RST_HOLD - 1);
  localparam logic [SEL_W:0]   N_LIM  = (SEL_W + 1)'(N_DESIGNS);
  localparam logic [SEL_W-1:0] DEF    = SEL_W'(DEFAULT_SEL);

  adapter_state_e   r_state,  w_state_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [SEL_W-1:0] r_pend,   w_pend_nxt;
  logic [SEL_W-1:0] r_active, w_active_nxt;
  logic             r_queued, w_queued_nxt;
  logic             r_sel_err;
  logic             w_sel_valid;
  logic             w_sel_err_nxt;

  assign w_sel_valid   = i_sel_load && ({1'b0, i_sel_in} < N_LIM);
  assign w_sel_err_nxt = i_sel_load && !w_sel_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RESET;
      r_cnt     <= R_INIT;
      r_pend    <= DEF;
      r_active  <= DEF;
      r_queued  <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pend    <= w_pend_nxt;
      r_active  <= w_active_nxt;
      r_queued  <= w_queued_nxt;
      r_sel_err <= w_sel_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pend_nxt   = w_sel_valid ? i_sel_in : r_pend;
    w_active_nxt = r_active;
    w_queued_nxt = r_queued;
    case (r_state)
      RUN: begin
        // Reselecting the running design is a deliberate soft reset.
        if (w_sel_valid) begin
          w_state_nxt = QUIESCE;
          w_cnt_nxt   = Q_INIT;
        end
      end
      QUIESCE: begin
        if (r_cnt == '0) begin
          w_state_nxt  = RESET;
          w_cnt_nxt    = R_INIT;
          w_active_nxt = w_pend_nxt;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      RESET: begin
        w_queued_nxt = r_queued || w_sel_valid;
        if (r_cnt == '0) begin
          if (w_queued_nxt) begin
            w_state_nxt  = QUIESCE;
            w_cnt_nxt    = Q_INIT;
            w_queued_nxt = 1'b0;
          end else begin
            w_state_nxt = RUN;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = RESET;
        w_cnt_nxt   = R_INIT;
      end
    endcase
  end

  assign o_state      = r_state;
  assign o_active_sel = r_active;
  assign o_sel_err    = r_sel_err;

endmodule

// File: rtl/tt_multi_design_adapter.sv
// Hosts N_DESIGNS designs behind one pad set: one-hot ena/rst_n decode and
// safe-forced output mux. Define ADAPTER_OUT_REG_EN to register the pad outputs.
module tt_multi_design_adapter
  import tt_adapter_pkg::*;
#(
  parameter int N_DESIGNS   = 4,
  parameter int SEL_W       = 2,
  parameter int DEFAULT_SEL = 0,
  parameter int RST_HOLD    = 16,
  parameter int QUIESCE_CYC = 2
) (
  input logic                      clk,
  input logic                      rst_n,
  tt_multi_design_adapter_if.slave bus
);

  localparam int BUS_MAX_W = TT_BUS_W * MAX_DESIGNS;

  adapter_state_e         w_state;
  logic [SEL_W-1:0]       w_active;
  logic                   w_sel_err;
  logic [N_DESIGNS-1:0]   w_onehot;
  logic                   w_live;
  logic                   w_run;
  logic [TT_BUS_W-1:0]    w_uo, w_uio, w_oe;
  logic [BUS_MAX_W-1:0]   w_uo_bus, w_uio_bus, w_oe_bus;

  tt_rst_sequencer #(
    .N_DESIGNS  (N_DESIGNS),
    .SEL_W      (SEL_W),
    .DEFAULT_SEL(DEFAULT_SEL),
    .RST_HOLD   (RST_HOLD),
    .QUIESCE_CYC(QUIESCE_CYC)
  ) u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sel_in    (bus.sel_in),
    .i_sel_load  (bus.sel_load),
    .o_state     (w_state),
    .o_active_sel(w_active),
    .o_sel_err   (w_sel_err)
  );

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < N_DESIGNS; i++) begin
      w_onehot[i] = (w_active == SEL_W'(i));
    end
  end

  // The outgoing design stays enabled through QUIESCE; everyone is held in RESET.
  assign w_live      = (w_state != RESET);
  assign w_run       = (w_state == RUN);
  assign bus.d_ena   = w_live ? w_onehot : '0;
  assign bus.d_rst_n = w_live ? w_onehot : '0;

  assign w_uo_bus  = BUS_MAX_W'(bus.d_uo_out);
  assign w_uio_bus = BUS_MAX_W'(bus.d_uio_out);
  assign w_oe_bus  = BUS_MAX_W'(bus.d_uio_oe);

  assign w_uo  = w_run ? slice8(w_uo_bus,  4'(w_active)) : '0;
  assign w_uio = w_run ? slice8(w_uio_bus, 4'(w_active)) : '0;
  assign w_oe  = w_run ? slice8(w_oe_bus,  4'(w_active)) : '0;

`ifdef ADAPTER_OUT_REG_EN
  logic [TT_BUS_W-1:0] r_uo, r_uio, r_oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uo  <= '0;
      r_uio <= '0;
      r_oe  <= '0;
    end else begin
      r_uo  <= w_uo;
      r_uio <= w_uio;
      r_oe  <= w_oe;
    end
  end

  assign bus.uo_out  = r_uo;
  assign bus.uio_out = r_uio;
  assign bus.uio_oe  = r_oe;
`else
  assign bus.uo_out  = w_uo;
  assign bus.uio_out = w_uio;
  assign bus.uio_oe  = w_oe;
`endif

  assign bus.active_sel = w_active;
  assign bus.busy       = !w_run;
  assign bus.sel_err    = w_sel_err;
  assign bus.dbg_state  = w_state;

endmodule

// File: tb/tb_tt_multi_design_adapter.sv
// Bench for tt_multi_design_adapter (N_DESIGNS=3): directed table, latency and
// async-reset sequences, then random loads against a phase-schedule model.
module tb_tt_multi_design_adapter;
  import tt_adapter_pkg::*;

  localparam int N   = 3;
  localparam int SW  = 2;
  localparam int DEF = 0;
  localparam int RH  = 16;
  localparam int QC  = 2;
`ifdef ADAPTER_OUT_REG_EN
  localparam int OUT_LAT = 1;
`else
  localparam int OUT_LAT = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tt_multi_design_adapter_if #(.N_DESIGNS(N), .SEL_W(SW)) bus ();

  tt_multi_design_adapter #(
    .N_DESIGNS(N), .SEL_W(SW), .DEFAULT_SEL(DEF), .RST_HOLD(RH), .QUIESCE_CYC(QC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase_q holds the remaining switch schedule, one entry per cycle:
  // 0 = quiesce (old design), 1 = reset (new design). Empty means running.
  logic       phase_q[$];
  int         m_active, m_pend;
  bit         m_queued, m_err;
  logic [7:0] m_uo_reg, m_uio_reg, m_oe_reg;

  function automatic logic [7:0] slot(input logic [8*N-1:0] b, input int i);
    logic [8*N-1:0] t;
    t = b >> (8 * i);
    return t[7:0];
  endfunction

  function automatic void push_switch();
    for (int i = 0; i < QC; i++) phase_q.push_back(1'b0);
    for (int i = 0; i < RH; i++) phase_q.push_back(1'b1);
  endfunction

  function automatic void model_reset();
    phase_q.delete();
    for (int i = 0; i < RH; i++) phase_q.push_back(1'b1);
    m_active  = DEF;
    m_pend    = DEF;
    m_queued  = 1'b0;
    m_err     = 1'b0;
    m_uo_reg  = '0;
    m_uio_reg = '0;
    m_oe_reg  = '0;
  endfunction

  task automatic compare_model();
    bit             running, live;
    logic [N-1:0]   oh;
    logic [7:0]     e_uo, e_uio, e_oe;
    running = (phase_q.size() == 0);
    live    = running || (phase_q[0] == 1'b0);
    oh = '0;
    oh[m_active] = 1'b1;
    e_uo  = running ? slot(bus.d_uo_out,  m_active) : 8'h00;
    e_uio = running ? slot(bus.d_uio_out, m_active) : 8'h00;
    e_oe  = running ? slot(bus.d_uio_oe,  m_active) : 8'h00;
`ifdef ADAPTER_OUT_REG_EN
    e_uo  = m_uo_reg;
    e_uio = m_uio_reg;
    e_oe  = m_oe_reg;
`endif
    check("m_uo_out",     bus.uo_out,     e_uo);
    check("m_uio_out",    bus.uio_out,    e_uio);
    check("m_uio_oe",     bus.uio_oe,     e_oe);
    check("m_d_ena",      bus.d_ena,      live ? oh : '0);
    check("m_d_rst_n",    bus.d_rst_n,    live ? oh : '0);
    check("m_busy",       bus.busy,       !running);
    check("m_active_sel", bus.active_sel, m_active);
    check("m_sel_err",    bus.sel_err,    m_err);
  endtask

  function automatic void model_step(input logic load, input int sel);
    bit running, valid, was;
    if (!rst_n) begin
      model_reset();
      return;
    end
    running   = (phase_q.size() == 0);
    m_uo_reg  = running ? slot(bus.d_uo_out,  m_active) : 8'h00;
    m_uio_reg = running ? slot(bus.d_uio_out, m_active) : 8'h00;
    m_oe_reg  = running ? slot(bus.d_uio_oe,  m_active) : 8'h00;
    valid = load && (sel < N);
    m_err = load && !valid;
    if (running) begin
      if (valid) begin
        m_pend = sel;
        push_switch();
      end
    end else begin
      if (valid) begin
        m_pend = sel;
        if (phase_q[0]) m_queued = 1'b1;
      end
      was = phase_q.pop_front();
      if (!was && phase_q.size() > 0 && phase_q[0]) m_active = m_pend;
      if (was && phase_q.size() == 0 && m_queued) begin
        push_switch();
        m_queued = 1'b0;
      end
    end
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic load, input logic [SW-1:0] sel);
    bus.sel_load = load;
    bus.sel_in   = sel;
    @(negedge clk);
    compare_model();
    @(posedge clk);
    model_step(load, int'(sel));
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        load;
    logic [1:0]  sel;
    int          idle;
    logic [1:0]  act;
    logic        busy;
    logic        err;
    logic [2:0]  ena;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int k;
    bus.sel_load  = 1'b0;
    bus.sel_in    = '0;
    bus.ui_in     = 8'h00;
    bus.uio_in    = 8'h00;
    bus.d_uo_out  = {8'h5A, 8'hA5, 8'h3C};
    bus.d_uio_out = {8'h22, 8'h11, 8'h00};
    bus.d_uio_oe  = {8'h0F, 8'hF0, 8'hFF};
    model_reset();

    // switch to 1, invalid load, then switch to 2 with a load queued during RESET
    tbl[0]  = '{1'b1, 2'd1, 0,  2'd0, 1'b1, 1'b0, 3'b001};
    tbl[1]  = '{1'b0, 2'd0, 1,  2'd1, 1'b1, 1'b0, 3'b000};
    tbl[2]  = '{1'b0, 2'd0, 15, 2'd1, 1'b0, 1'b0, 3'b010};
    tbl[3]  = '{1'b1, 2'd3, 0,  2'd1, 1'b0, 1'b1, 3'b010};
    tbl[4]  = '{1'b0, 2'd0, 0,  2'd1, 1'b0, 1'b0, 3'b010};
    tbl[5]  = '{1'b1, 2'd2, 0,  2'd1, 1'b1, 1'b0, 3'b010};
    tbl[6]  = '{1'b0, 2'd0, 1,  2'd2, 1'b1, 1'b0, 3'b000};
    tbl[7]  = '{1'b1, 2'd1, 0,  2'd2, 1'b1, 1'b0, 3'b000};
    tbl[8]  = '{1'b0, 2'd0, 13, 2'd2, 1'b1, 1'b0, 3'b000};
    tbl[9]  = '{1'b0, 2'd0, 0,  2'd2, 1'b1, 1'b0, 3'b100};
    tbl[10] = '{1'b0, 2'd0, 1,  2'd1, 1'b1, 1'b0, 3'b000};
    tbl[11] = '{1'b0, 2'd0, 15, 2'd1, 1'b0, 1'b0, 3'b010};

    // reset state
    repeat (3) step(1'b0, 2'd0);
    check("rst_uo_out",  bus.uo_out,     8'h00);
    check("rst_busy",    bus.busy,       1'b1);
    check("rst_d_rst_n", bus.d_rst_n,    3'b000);
    check("rst_active",  bus.active_sel, 2'(DEF));

    // release: d_rst_n[0] rises exactly RH cycles later
    rst_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 2'd0);
      if (bus.d_rst_n[0] === 1'b1) begin
        k = i;
        break;
      end
    end
    check("release_latency", k, RH);
    check("release_busy",    bus.busy,  1'b0);
    check("release_d_ena",   bus.d_ena, 3'b001);

    for (int v = 0; v < 12; v++) begin
      step(tbl[v].load, tbl[v].sel);
      repeat (tbl[v].idle) step(1'b0, 2'd0);
      check($sformatf("tbl%0d_active", v), bus.active_sel, tbl[v].act);
      check($sformatf("tbl%0d_busy", v),   bus.busy,       tbl[v].busy);
      check($sformatf("tbl%0d_err", v),    bus.sel_err,    tbl[v].err);
      check($sformatf("tbl%0d_ena", v),    bus.d_ena,      tbl[v].ena);
      check($sformatf("tbl%0d_rst_n", v),  bus.d_rst_n,    tbl[v].ena);
    end

    // async reset in the middle of design 2's RESET phase
    step(1'b1, 2'd2);
    repeat (5) step(1'b0, 2'd0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("abort_uo_out",  bus.uo_out,     8'h00);
    check("abort_uio_out", bus.uio_out,    8'h00);
    check("abort_uio_oe",  bus.uio_oe,     8'h00);
    check("abort_d_ena",   bus.d_ena,      3'b000);
    check("abort_d_rst_n", bus.d_rst_n,    3'b000);
    check("abort_busy",    bus.busy,       1'b1);
    check("abort_active",  bus.active_sel, 2'(DEF));
    repeat (2) step(1'b0, 2'd0);
    rst_n = 1'b1;
    repeat (RH) step(1'b0, 2'd0);
    check("abort_recover_active", bus.active_sel, 2'(DEF));
    check("abort_recover_busy",   bus.busy,       1'b0);

    // load-to-output latency for a switch to design 1
    k = 0;
    step(1'b1, 2'd1);
    for (int i = 1; i <= 40; i++) begin
      if (bus.uo_out === 8'hA5) begin
        k = i;
        break;
      end
      step(1'b0, 2'd0);
    end
    check("switch_uo_latency", k, 1 + QC + RH + OUT_LAT);
    check("switch_d_ena",      bus.d_ena, 3'b010);
    check("switch_active",     bus.active_sel, 2'd1);

    // randomized loads, design outputs and occasional async resets
    for (int i = 0; i < 600; i++) begin
      bus.d_uo_out  = 24'($urandom);
      bus.d_uio_out = 24'($urandom);
      bus.d_uio_oe  = 24'($urandom);
      bus.ui_in     = 8'($urandom);
      bus.uio_in    = 8'($urandom);
      if (rst_n == 1'b0) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end
      step($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
